// File: rtl/bcd_display_ctrl_pkg.sv
// Shared constants, state encoding and sizing helpers for the BCD display controller.
package calc_disp_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        CONV   = ST_CONV,
        FINISH = ST_FINISH
    } state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // One spare nibble above the shown digits, widened when WIDTH needs more decimal digits.
    function automatic int bcd_nibbles(input int width, input int digits);
        int need;
        need = (width * 30103 + 99999) / 100000;
        return (need > digits + 1) ? need : digits + 1;
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_if.sv
// Request/result bundle between the ALU side and the BCD display controller.
interface bcd_display_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    // start is accepted on an edge where busy=0; done pulses for one cycle when
    // digits/neg/ovf take their new values, and those hold until the next done.
    logic                start;
    logic [WIDTH-1:0]    value;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] digits;
    logic                neg;
    logic                ovf;
    logic [1:0]          state;

    modport master (output start, value, input busy, done, digits, neg, ovf, state);
    modport slave  (input start, value, output busy, done, digits, neg, ovf, state);
endinterface

// File: rtl/bcd_display_ctrl_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble of 5 or more.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_display_ctrl.sv
// Iterative binary-to-BCD converter with sign, overflow and leading-zero blanking.
module bcd_display_ctrl
    import calc_disp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter bit SIGNED = 1'b1
) (
    input logic              clk,
    input logic              rst,
    bcd_display_ctrl_if.slave bus
);
    localparam int NB = bcd_nibbles(WIDTH, DIGITS);
    localparam int CW = cnt_width(WIDTH);

    state_e              state, state_nx;
    logic [WIDTH-1:0]    mag;
    logic [4*NB-1:0]     bcd, bcd_adj;
    logic [CW-1:0]       cnt;
    logic                sign_r;
    logic [4*DIGITS-1:0] digits_r, disp;
    logic                done_r, neg_r, ovf_r;
    logic                ovf_c, neg_c, lead;

    for (genvar g = 0; g < NB; g++) begin : g_add3
        bcd_add3 u_add3 (.din(bcd[4*g +: 4]), .dout(bcd_adj[4*g +: 4]));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = CONV;
            CONV:    if (cnt == CW'(WIDTH - 1)) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Anything in the nibbles above the shown digits cannot be displayed.
    always_comb begin
        ovf_c = |bcd[4*NB-1:4*DIGITS];
        neg_c = sign_r & (|bcd) & ~ovf_c;
        lead  = 1'b1;
        disp  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead = lead && (bcd[4*i +: 4] == 4'd0) && (i > 0);
            disp[4*i +: 4] = (lead || ovf_c) ? BLANK_CODE : bcd[4*i +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mag      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            sign_r   <= 1'b0;
            digits_r <= {DIGITS{BLANK_CODE}};
            done_r   <= 1'b0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    mag    <= (SIGNED && bus.value[WIDTH-1]) ? (~bus.value + 1'b1) : bus.value;
                    sign_r <= SIGNED & bus.value[WIDTH-1];
                    bcd    <= '0;
                    cnt    <= '0;
                end
                CONV: begin
                    {bcd, mag} <= {bcd_adj[4*NB-2:0], mag, 1'b0};
                    cnt        <= cnt + 1'b1;
                end
                FINISH: begin
                    digits_r <= disp;
                    neg_r    <= neg_c;
                    ovf_r    <= ovf_c;
                    done_r   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_r;
    assign bus.digits = digits_r;
    assign bus.neg    = neg_r;
    assign bus.ovf    = ovf_r;
    assign bus.state  = state;
endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench: a 3-digit and a 2-digit controller driven with the same requests.
module tb_bcd_display_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   lat;
    int   ndone;
    int   t1, t2, t3;

    always #5 clk = ~clk;

    bcd_display_ctrl_if #(.WIDTH(8), .DIGITS(3)) bus  ();
    bcd_display_ctrl_if #(.WIDTH(8), .DIGITS(2)) bus2 ();

    bcd_display_ctrl #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
    bcd_display_ctrl #(.WIDTH(8), .DIGITS(2), .SIGNED(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic s, input logic [7:0] v);
        bus.start  = s;
        bus.value  = v;
        bus2.start = s;
        bus2.value = v;
    endtask

    // Start pulse lasting one posedge (edge k); returns at the negedge after edge k.
    task automatic launch(input logic [7:0] v);
        @(negedge clk);
        drive(1'b1, v);
        @(negedge clk);
        drive(1'b0, 8'h00);
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
    endtask

    initial begin
        drive(1'b0, 8'h00);
        #2 rst = 1'b1;
        #3;
        check("rst_digits", bus.digits, 12'hFFF);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_neg", bus.neg, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        check("rst_state", bus.state, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // 123: busy through the conversion, done after edge k+9
        launch(8'd123);
        check("123_busy_k", bus.busy, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("123_busy_k%0d", i), bus.busy, 1'b1);
            check($sformatf("123_nodone_k%0d", i), bus.done, 1'b0);
            check($sformatf("123_hold_k%0d", i), bus.digits, 12'hFFF);
        end
        @(negedge clk);
        check("123_done", bus.done, 1'b1);
        check("123_busy_end", bus.busy, 1'b0);
        check("123_digits", bus.digits, 12'h123);
        check("123_neg", bus.neg, 1'b0);
        check("123_ovf", bus.ovf, 1'b0);
        check("123_d2_ovf", bus2.ovf, 1'b1);
        check("123_d2_digits", bus2.digits, 8'hFF);
        @(negedge clk);
        check("123_done_pulse", bus.done, 1'b0);
        check("123_digits_hold", bus.digits, 12'h123);

        launch(8'hF9);
        wait_done(lat);
        check("m7_latency", lat, 9);
        check("m7_digits", bus.digits, 12'hFF7);
        check("m7_neg", bus.neg, 1'b1);
        check("m7_ovf", bus.ovf, 1'b0);
        check("m7_d2_digits", bus2.digits, 8'hF7);
        check("m7_d2_neg", bus2.neg, 1'b1);

        launch(8'h00);
        wait_done(lat);
        check("zero_latency", lat, 9);
        check("zero_digits", bus.digits, 12'hFF0);
        check("zero_neg", bus.neg, 1'b0);

        launch(8'h80);
        wait_done(lat);
        check("m128_latency", lat, 9);
        check("m128_digits", bus.digits, 12'h128);
        check("m128_neg", bus.neg, 1'b1);
        check("m128_ovf", bus.ovf, 1'b0);
        check("m128_d2_ovf", bus2.ovf, 1'b1);
        check("m128_d2_digits", bus2.digits, 8'hFF);
        check("m128_d2_neg", bus2.neg, 1'b0);

        launch(8'd90);
        wait_done(lat);
        check("90_digits", bus.digits, 12'hF90);
        check("90_d2_digits", bus2.digits, 8'h90);
        check("90_d2_ovf", bus2.ovf, 1'b0);

        // start during CONV and during FINISH must be ignored
        launch(8'd45);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            drive(i == 3, 8'd99);
        end
        check("ign_state_finish", bus.state, 2'd2);
        drive(1'b1, 8'd99);
        @(negedge clk);
        drive(1'b0, 8'h00);
        check("ign_done", bus.done, 1'b1);
        check("ign_digits", bus.digits, 12'hF45);
        count_dones(15, ndone);
        check("ign_extra_dones", ndone, 0);

        // start held high relaunches every 10 cycles
        @(negedge clk);
        drive(1'b1, 8'h07);
        t1 = -1; t2 = -1; t3 = -1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
                else if (t3 < 0) t3 = i;
            end
        end
        drive(1'b0, 8'h00);
        check("held_first", t1, 9);
        check("held_period1", t2 - t1, 10);
        check("held_period2", t3 - t2, 10);
        check("held_digits", bus.digits, 12'hFF7);
        count_dones(12, ndone);

        // reset mid-conversion aborts with no stale done
        launch(8'd200);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_digits", bus.digits, 12'hFFF);
        check("arst_done", bus.done, 1'b0);
        check("arst_neg", bus.neg, 1'b0);
        check("arst_ovf", bus.ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        count_dones(15, ndone);
        check("arst_no_stale_done", ndone, 0);
        launch(8'd45);
        wait_done(lat);
        check("post_rst_latency", lat, 9);
        check("post_rst_digits", bus.digits, 12'hF45);
        check("post_rst_neg", bus.neg, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
